// File: rtl/traffic_pkg.sv
// Shared lamp/phase types, default dwell times and lamp decode helpers
// for the intersection controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    ALL_RED1 = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    ALL_RED2 = 3'd5,
    PED_WALK = 3'd6
  } phase_t;

  localparam int unsigned DEF_MAIN_MIN = 8;
  localparam int unsigned DEF_SIDE_T   = 6;
  localparam int unsigned DEF_YEL_T    = 3;
  localparam int unsigned DEF_AR_T     = 2;
  localparam int unsigned DEF_WALK_T   = 5;

  // Each road's lamp is a pure function of the phase, so the two roads can
  // never show a non-red aspect in the same phase.
  function automatic light_t mainLamp(input phase_t ph);
    light_t lamp;
    lamp = RED;
    if (ph == MAIN_GRN) lamp = GREEN;
    else if (ph == MAIN_YEL) lamp = YELLOW;
    return lamp;
  endfunction

  function automatic light_t sideLamp(input phase_t ph);
    light_t lamp;
    lamp = RED;
    if (ph == SIDE_GRN) lamp = GREEN;
    else if (ph == SIDE_YEL) lamp = YELLOW;
    return lamp;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that holds at zero; o_zero flags the final cycle of a phase.
module phase_timer #(
  parameter int unsigned   W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with optional pedestrian walk phase.
// Define INTERSECTION_PED_WALK_EN to build the pedestrian walk phase.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned MAIN_MIN = DEF_MAIN_MIN,
  parameter int unsigned SIDE_T   = DEF_SIDE_T,
  parameter int unsigned YEL_T    = DEF_YEL_T,
  parameter int unsigned AR_T     = DEF_AR_T,
  parameter int unsigned WALK_T   = DEF_WALK_T
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   side_req,
  input  logic   ped_req,
  output light_t main_color,
  output light_t side_color,
  output logic   walk,
  output logic   ped_ack,
  output phase_t phase
);

  localparam logic [7:0] MAIN_LD = 8'(MAIN_MIN - 1);
  localparam logic [7:0] SIDE_LD = 8'(SIDE_T - 1);
  localparam logic [7:0] YEL_LD  = 8'(YEL_T - 1);
  localparam logic [7:0] AR_LD   = 8'(AR_T - 1);
  localparam logic [7:0] WALK_LD = 8'(WALK_T - 1);

  phase_t     r_state;
  phase_t     w_next;
  light_t     r_main_color;
  light_t     r_side_color;
  logic       r_side_pend;
  logic       w_ped_pend;
  logic       w_zero;
  logic       w_load;
  logic [7:0] w_load_val;
  logic       w_enter_side;
  logic       w_enter_walk;

  phase_timer #(
    .W       (8),
    .RST_VAL (AR_LD)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  // Next phase; every transition lands in a different state, so a state
  // change is exactly the timer reload condition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MAIN_GRN: if (w_zero && (r_side_pend || w_ped_pend)) w_next = MAIN_YEL;
      MAIN_YEL: if (w_zero) w_next = ALL_RED1;
      ALL_RED1: if (w_zero) w_next = w_ped_pend ? PED_WALK : SIDE_GRN;
      SIDE_GRN: if (w_zero) w_next = SIDE_YEL;
      SIDE_YEL: if (w_zero) w_next = ALL_RED2;
      ALL_RED2: if (w_zero) w_next = MAIN_GRN;
      PED_WALK: if (w_zero) w_next = ALL_RED2;
      default:  w_next = ALL_RED2;
    endcase
  end

  always_comb begin
    w_load_val = AR_LD;
    case (w_next)
      MAIN_GRN:           w_load_val = MAIN_LD;
      MAIN_YEL, SIDE_YEL: w_load_val = YEL_LD;
      SIDE_GRN:           w_load_val = SIDE_LD;
      PED_WALK:           w_load_val = WALK_LD;
      default:            w_load_val = AR_LD;
    endcase
  end

  assign w_load       = (w_next != r_state);
  assign w_enter_side = (w_next == SIDE_GRN) && (r_state != SIDE_GRN);
  assign w_enter_walk = (w_next == PED_WALK) && (r_state != PED_WALK);

  // Lamps are decoded from the next phase so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ALL_RED2;
      r_main_color <= RED;
      r_side_color <= RED;
    end else begin
      r_state      <= w_next;
      r_main_color <= mainLamp(w_next);
      r_side_color <= sideLamp(w_next);
    end
  end

  // A new request arriving on the entry cycle must survive the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_side_pend <= 1'b0;
    end else if (side_req) begin
      r_side_pend <= 1'b1;
    end else if (w_enter_side) begin
      r_side_pend <= 1'b0;
    end
  end

`ifdef INTERSECTION_PED_WALK_EN
  logic r_ped_pend;
  logic r_walk;
  logic r_ped_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ped_pend <= 1'b0;
    end else if (ped_req) begin
      r_ped_pend <= 1'b1;
    end else if (w_enter_walk) begin
      r_ped_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_walk    <= 1'b0;
      r_ped_ack <= 1'b0;
    end else begin
      r_walk    <= (w_next == PED_WALK);
      r_ped_ack <= w_enter_walk;
    end
  end

  assign w_ped_pend = r_ped_pend;
  assign walk       = r_walk;
  assign ped_ack    = r_ped_ack;
`else
  logic w_unused_ped;
  assign w_unused_ped = ped_req ^ w_enter_walk;
  assign w_ped_pend   = 1'b0;
  assign walk         = 1'b0;
  assign ped_ack      = 1'b0;
`endif

  assign main_color = r_main_color;
  assign side_color = r_side_color;
  assign phase      = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Table-driven scoreboard bench for intersection_ctrl at default timings;
// pedestrian scenarios are built when INTERSECTION_PED_WALK_EN is defined.
module tb_intersection_ctrl;
  import traffic_pkg::*;

  typedef struct packed {
    phase_t ph;
    light_t mainC;
    light_t sideC;
    logic   walk;
    logic   ack;
  } obs_t;

  typedef struct {
    logic   side;
    logic   ped;
    phase_t ph;
    int     reps;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   sideReq = 1'b0;
  logic   pedReq = 1'b0;
  light_t mainColor;
  light_t sideColor;
  logic   walk;
  logic   pedAck;
  phase_t phase;

  vec_t   plan[$];
  obs_t   expQ[$];
  int     vectors = 0;
  int     miscompares = 0;
  phase_t lastPh = ALL_RED2;

  intersection_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .side_req   (sideReq),
    .ped_req    (pedReq),
    .main_color (mainColor),
    .side_color (sideColor),
    .walk       (walk),
    .ped_ack    (pedAck),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Expected outputs for a phase, straight from the lamp table.
  function automatic obs_t expectFor(input phase_t ph, input logic first);
    obs_t o;
    o.ph = ph;
    o.mainC = RED;
    o.sideC = RED;
    o.walk = 1'b0;
    o.ack = 1'b0;
    case (ph)
      MAIN_GRN: o.mainC = GREEN;
      MAIN_YEL: o.mainC = YELLOW;
      SIDE_GRN: o.sideC = GREEN;
      SIDE_YEL: o.sideC = YELLOW;
      PED_WALK: begin
        o.walk = 1'b1;
        o.ack = first;
      end
      default: ;
    endcase
    return o;
  endfunction

  task automatic addVec(input logic s, input logic p, input phase_t ph, input int n);
    vec_t v;
    v.side = s;
    v.ped = p;
    v.ph = ph;
    v.reps = n;
    plan.push_back(v);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input obs_t e);
    sideReq = s;
    pedReq = p;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int step);
    obs_t got;
    obs_t e;
    got.ph = phase;
    got.mainC = mainColor;
    got.sideC = sideColor;
    got.walk = walk;
    got.ack = pedAck;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s step %0d: scoreboard empty, got phase=%0d", name, step, got.ph);
    end else begin
      e = expQ.pop_front();
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL %s step %0d: got phase=%0d main=%0d side=%0d walk=%b ack=%b, expected phase=%0d main=%0d side=%0d walk=%b ack=%b",
                 name, step, got.ph, got.mainC, got.sideC, got.walk, got.ack,
                 e.ph, e.mainC, e.sideC, e.walk, e.ack);
      end
    end
  endtask

  // Called on a falling edge; each vector record expands to reps clock cycles.
  task automatic runPlan(input string name);
    int step;
    obs_t e;
    step = 0;
    for (int i = 0; i < plan.size(); i++) begin
      for (int r = 0; r < plan[i].reps; r++) begin
        e = expectFor(plan[i].ph, (plan[i].ph == PED_WALK) && (lastPh != PED_WALK));
        lastPh = plan[i].ph;
        applyStimulus(plan[i].side, plan[i].ped, e);
        @(posedge clk);
        @(negedge clk);
        step++;
        checkOutput(name, step);
      end
    end
    plan.delete();
    sideReq = 1'b0;
    pedReq = 1'b0;
  endtask

  // Asserts reset offset from a falling edge, checks it took effect before any
  // clock edge and again after one edge, then releases on the next falling edge.
  task automatic doReset(input string name, input int offset);
    #(offset);
    rst = 1'b0;
    sideReq = 1'b0;
    pedReq = 1'b0;
    #1;
    applyStimulus(1'b0, 1'b0, expectFor(ALL_RED2, 1'b0));
    checkOutput({name, "_rstAsync"}, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, expectFor(ALL_RED2, 1'b0));
    checkOutput({name, "_rstHeld"}, 0);
    lastPh = ALL_RED2;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Power-on reset, released at t=10; idle road stays green on main.
    #1 rst = 1'b0;
    #2;
    applyStimulus(1'b0, 1'b0, expectFor(ALL_RED2, 1'b0));
    checkOutput("porReset", 0);
    @(negedge clk);
    rst = 1'b1;
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 30);
    runPlan("idleHold");

    // Side pulse in the 3rd main-green cycle, then a pulse against a saturated timer.
    doReset("sidePulse", 0);
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 3);
    addVec(1, 0, MAIN_GRN, 1);
    addVec(0, 0, MAIN_GRN, 4);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, SIDE_GRN, 6);
    addVec(0, 0, SIDE_YEL, 3);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 12);
    addVec(1, 0, MAIN_GRN, 1);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, SIDE_GRN, 6);
    addVec(0, 0, SIDE_YEL, 3);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 5);
    runPlan("sidePulse");

    // Held side request: set wins over the clear on side-green entry.
    doReset("sideLevel", 0);
    addVec(1, 0, ALL_RED2, 1);
    addVec(1, 0, MAIN_GRN, 8);
    addVec(1, 0, MAIN_YEL, 3);
    addVec(1, 0, ALL_RED1, 2);
    addVec(1, 0, SIDE_GRN, 6);
    addVec(1, 0, SIDE_YEL, 3);
    addVec(1, 0, ALL_RED2, 2);
    addVec(1, 0, MAIN_GRN, 8);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, SIDE_GRN, 6);
    addVec(0, 0, SIDE_YEL, 3);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 10);
    runPlan("sideLevel");

    // Reset mid side-green with a fresh side request pending: request is lost.
    doReset("midReset", 0);
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 1);
    addVec(1, 0, MAIN_GRN, 1);
    addVec(0, 0, MAIN_GRN, 6);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, SIDE_GRN, 1);
    addVec(1, 0, SIDE_GRN, 1);
    addVec(0, 0, SIDE_GRN, 1);
    runPlan("midResetPre");
    doReset("midReset", 2);
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 15);
    runPlan("midResetPost");

`ifdef INTERSECTION_PED_WALK_EN
    // Pedestrian pulse during main green.
    doReset("pedPulse", 0);
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 2);
    addVec(0, 1, MAIN_GRN, 1);
    addVec(0, 0, MAIN_GRN, 5);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, PED_WALK, 5);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 10);
    runPlan("pedPulse");

    // Simultaneous side and pedestrian requests: walk first, side after next main green.
    doReset("bothReq", 0);
    addVec(0, 0, ALL_RED2, 1);
    addVec(0, 0, MAIN_GRN, 2);
    addVec(1, 1, MAIN_GRN, 1);
    addVec(0, 0, MAIN_GRN, 5);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, PED_WALK, 5);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 8);
    addVec(0, 0, MAIN_YEL, 3);
    addVec(0, 0, ALL_RED1, 2);
    addVec(0, 0, SIDE_GRN, 6);
    addVec(0, 0, SIDE_YEL, 3);
    addVec(0, 0, ALL_RED2, 2);
    addVec(0, 0, MAIN_GRN, 6);
    runPlan("bothReq");
`else
    // Without the walk phase a held pedestrian button changes nothing.
    doReset("pedIgnored", 0);
    addVec(0, 1, ALL_RED2, 1);
    addVec(0, 1, MAIN_GRN, 25);
    runPlan("pedIgnored");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
